// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the RV32I/RV64I immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_Z
    } imm_fmt_t;

    // Entries always carry a 64-bit immediate; the top truncates to XLEN.
    localparam int IMM_W = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_t         fmt;
        logic             illegal;
    } imm_entry_t;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> immediate/format/illegal decode.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] instr,
    output imm_entry_t  entry
);
    logic [6:0] opc;
    logic [2:0] funct3;
    logic       is_shift;

    assign opc      = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        entry.imm     = '0;
        entry.fmt     = FMT_NONE;
        entry.illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            entry.illegal = 1'b1;
        end else begin
            case (opc)
                OPC_STORE: begin
                    entry.fmt = FMT_S;
                    entry.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    entry.fmt = FMT_B;
                    entry.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                OPC_LOAD, OPC_JALR: begin
                    entry.fmt = FMT_I;
                    entry.imm = {{52{instr[31]}}, instr[31:20]};
                end
                OPC_OP_IMM: begin
                    if (is_shift) begin
                        entry.fmt = FMT_SH;
                        if (XLEN == 64) begin
                            entry.imm = {58'b0, instr[25:20]};
                        end else begin
                            // shamt[5] set is an out-of-range shift on RV32
                            entry.imm     = {59'b0, instr[24:20]};
                            entry.illegal = instr[25];
                        end
                    end else begin
                        entry.fmt = FMT_I;
                        entry.imm = {{52{instr[31]}}, instr[31:20]};
                    end
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        if (is_shift) begin
                            entry.fmt = FMT_SH;
                            entry.imm = {59'b0, instr[24:20]};
                        end else begin
                            entry.fmt = FMT_I;
                            entry.imm = {{52{instr[31]}}, instr[31:20]};
                        end
                    end else begin
                        entry.illegal = 1'b1;
                    end
                end
                OPC_LUI, OPC_AUIPC: begin
                    entry.fmt = FMT_U;
                    entry.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    entry.fmt = FMT_J;
                    entry.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    entry.fmt = FMT_Z;
                    entry.imm = {59'b0, instr[19:15]};
                end
                OPC_OP: ;
                OPC_OP_32: entry.illegal = (XLEN == 32);
                default:   entry.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeding a 2-entry head/skid FIFO with a registered in_ready.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        imm_fmt,
    output logic            illegal
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (DEPTH != 2) begin : g_bad_depth
        $error("imm_gen_pipe: DEPTH must be 2");
    end

    cnt_state_t state_q, state_d;
    imm_entry_t head_q, head_d, skid_q, skid_d, dec_entry;
    logic       push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (instr),
        .entry (dec_entry)
    );

    // Both handshake flags come straight from the state register.
    assign in_ready  = (state_q != CNT_FULL);
    assign out_valid = (state_q != CNT_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign imm     = head_q.imm[XLEN-1:0];
    assign imm_fmt = head_q.fmt;
    assign illegal = head_q.illegal;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            CNT_EMPTY: begin
                if (push) begin
                    head_d  = dec_entry;
                    state_d = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push && pop) begin
                    head_d = dec_entry;
                end else if (push) begin
                    skid_d  = dec_entry;
                    state_d = CNT_FULL;
                end else if (pop) begin
                    state_d = CNT_EMPTY;
                end
            end
            CNT_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = CNT_ONE;
                end
            end
            default: state_d = CNT_EMPTY;
        endcase
        // Entry data is left as-is on flush; only occupancy is dropped.
        if (flush) state_d = CNT_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CNT_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (int'(state_q) <= DEPTH);
            assert (!(push && state_q == CNT_FULL));
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> $stable(head_q));

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe at XLEN=64 and XLEN=32.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        iv64, ir64, ov64, or64, il64;
    logic [31:0] in64;
    logic [63:0] imm64;
    imm_fmt_t    f64;
    logic        iv32, ir32, ov32, or32, il32;
    logic [31:0] in32;
    logic [31:0] imm32;
    imm_fmt_t    f32;

    int   checks = 0;
    int   errors = 0;
    exp_t q64[$];
    exp_t q32[$];
    exp_t e64, e32;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv64), .in_ready(ir64),
        .instr(in64), .out_valid(ov64), .out_ready(or64), .imm(imm64),
        .imm_fmt(f64), .illegal(il64)
    );

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv32), .in_ready(ir32),
        .instr(in32), .out_valid(ov32), .out_ready(or32), .imm(imm32),
        .imm_fmt(f32), .illegal(il32)
    );

    // Monitors: pop the oldest expectation whenever a head entry is consumed.
    always @(negedge clk) begin
        if (!reset && ov64 && or64) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL out64_unexpected: got imm=%h fmt=%0d ill=%b, none expected", imm64, f64, il64);
            end else begin
                e64 = q64.pop_front();
                if (imm64 !== e64.imm || f64 !== e64.fmt || il64 !== e64.ill) begin
                    errors++;
                    $display("FAIL out64: got imm=%h fmt=%0d ill=%b, want imm=%h fmt=%0d ill=%b",
                             imm64, f64, il64, e64.imm, e64.fmt, e64.ill);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ov32 && or32) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL out32_unexpected: got imm=%h fmt=%0d ill=%b, none expected", imm32, f32, il32);
            end else begin
                e32 = q32.pop_front();
                if (imm32 !== e32.imm[31:0] || f32 !== e32.fmt || il32 !== e32.ill) begin
                    errors++;
                    $display("FAIL out32: got imm=%h fmt=%0d ill=%b, want imm=%h fmt=%0d ill=%b",
                             imm32, f32, il32, e32.imm[31:0], e32.fmt, e32.ill);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Present one instruction until accepted, then queue its expected result.
    task automatic send(input bit w64, input logic [31:0] ins, input exp_t e);
        bit acc = 1'b0;
        if (w64) begin iv64 = 1'b1; in64 = ins; end
        else     begin iv32 = 1'b1; in32 = ins; end
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = w64 ? ir64 : ir32;
            @(posedge clk); #1;
        end
        if (w64) iv64 = 1'b0; else iv32 = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: instr %h not accepted", ins);
        end else if (w64) q64.push_back(e);
        else              q32.push_back(e);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [31:0] v64_i [10];
        exp_t        v64_e [10];
        logic [31:0] v32_i [6];
        exp_t        v32_e [6];

        v64_i[0] = 32'hFFF00093; v64_e[0] = '{ONES, 3'd1, 1'b0};                   // addi -1
        v64_i[1] = 32'hFE112E23; v64_e[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0}; // sw -4
        v64_i[2] = 32'h80000063; v64_e[2] = '{64'hFFFF_FFFF_FFFF_F000, 3'd3, 1'b0}; // beq -4096
        v64_i[3] = 32'h000FD073; v64_e[3] = '{64'd31, 3'd7, 1'b0};                 // csrrwi 31
        v64_i[4] = 32'hFFF0009B; v64_e[4] = '{ONES, 3'd1, 1'b0};                   // addiw -1
        v64_i[5] = 32'h800000B7; v64_e[5] = '{64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // lui
        v64_i[6] = 32'hFFFFF06F; v64_e[6] = '{64'hFFFF_FFFF_FFFF_FFFE, 3'd5, 1'b0}; // jal -2
        v64_i[7] = 32'h03F09093; v64_e[7] = '{64'd63, 3'd6, 1'b0};                 // slli 63
        v64_i[8] = 32'h002081B3; v64_e[8] = '{64'd0, 3'd0, 1'b0};                  // add
        v64_i[9] = 32'h00000001; v64_e[9] = '{64'd0, 3'd0, 1'b1};                  // compressed

        v32_i[0] = 32'h02009093; v32_e[0] = '{64'd0, 3'd6, 1'b1};                  // slli 32
        v32_i[1] = 32'hFFF0009B; v32_e[1] = '{64'd0, 3'd0, 1'b1};                  // addiw
        v32_i[2] = 32'h0000007F; v32_e[2] = '{64'd0, 3'd0, 1'b1};                  // opcode 7F
        v32_i[3] = 32'hFFF00093; v32_e[3] = '{64'h0000_0000_FFFF_FFFF, 3'd1, 1'b0}; // addi -1
        v32_i[4] = 32'h800000B7; v32_e[4] = '{64'h0000_0000_8000_0000, 3'd4, 1'b0}; // lui
        v32_i[5] = 32'h0000003B; v32_e[5] = '{64'd0, 3'd0, 1'b1};                  // addw

        reset = 1'b1; flush = 1'b0;
        iv64 = 1'b0; in64 = '0; or64 = 1'b1;
        iv32 = 1'b0; in32 = '0; or32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(ov64), 64'd0);
        chk("rst_in_ready",  64'(ir64), 64'd1);
        chk("rst_imm",       imm64,     64'd0);
        chk("rst_fmt",       64'(f64),  64'd0);
        chk("rst_illegal",   64'(il64), 64'd0);
        reset = 1'b0;

        foreach (v64_i[k]) send(1'b1, v64_i[k], v64_e[k]);
        foreach (v32_i[k]) send(1'b0, v32_i[k], v32_e[k]);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two accepted, third held off, head stable.
        or64 = 1'b0;
        send(1'b1, v64_i[1], v64_e[1]);
        send(1'b1, v64_i[2], v64_e[2]);
        iv64 = 1'b1; in64 = v64_i[3];
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready",  64'(ir64), 64'd0);
            chk("bp_out_valid", 64'(ov64), 64'd1);
            chk("bp_imm_stable", imm64, v64_e[1].imm);
        end
        @(posedge clk); #1;
        or64 = 1'b1;
        send(1'b1, v64_i[3], v64_e[3]);
        repeat (4) @(posedge clk);
        #1;

        // Flush while full with a same-cycle push.
        or64 = 1'b0;
        send(1'b1, v64_i[5], v64_e[5]);
        send(1'b1, v64_i[6], v64_e[6]);
        iv64 = 1'b1; in64 = v64_i[7]; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; iv64 = 1'b0;
        q64.delete();
        chk("flush_out_valid", 64'(ov64), 64'd0);
        chk("flush_in_ready",  64'(ir64), 64'd1);
        or64 = 1'b1;
        send(1'b1, v64_i[8], v64_e[8]);
        repeat (3) @(posedge clk);
        #1;

        // Mid-stream reset clears occupancy and entry data.
        or64 = 1'b0;
        send(1'b1, v64_i[0], v64_e[0]);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(ov64), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q64.delete();
        chk("mrst_out_valid", 64'(ov64), 64'd0);
        chk("mrst_in_ready",  64'(ir64), 64'd1);
        chk("mrst_imm",       imm64,     64'd0);
        chk("mrst_fmt",       64'(f64),  64'd0);
        chk("mrst_illegal",   64'(il64), 64'd0);
        or64 = 1'b1;
        send(1'b1, v64_i[2], v64_e[2]);

        for (int n = 0; n < 100 && (q64.size() != 0 || q32.size() != 0); n++) @(posedge clk);
        #1;
        chk("drain_q64", 64'(q64.size()), 64'd0);
        chk("drain_q32", 64'(q32.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
